// File: rtl/payload_feeder_if.sv
// Bus between payload_feeder and its environment: payload loading, stream
// control, the character stream to the matcher and match reporting.
interface payload_feeder_if #(
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              wr_last;
  logic              start;
  logic              ifFinal;
  logic [7:0]        input_ch;
  logic              ch_valid;
  logic              mat_reset;
  logic              ready;
  logic              busy;
  logic              overflow;
  logic              match_valid;
  logic [ADDR_W-1:0] match_offset;
  logic [7:0]        match_count;
  logic              done;

  modport master (
    output wr_en, wr_data, wr_last, start, ifFinal,
    input  input_ch, ch_valid, mat_reset, ready, busy, overflow,
           match_valid, match_offset, match_count, done
  );

  modport slave (
    input  wr_en, wr_data, wr_last, start, ifFinal,
    output input_ch, ch_valid, mat_reset, ready, busy, overflow,
           match_valid, match_offset, match_count, done
  );
endinterface

// File: rtl/payload_feeder.sv
// Buffers a payload, streams it byte by byte into a character matcher and
// collects the matcher's delayed accept flags as offset-tagged match reports.
module payload_feeder #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int MATCH_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  payload_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_READY  = 3'd1,
    S_PRIME  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [2:0]        drain_q, drain_d;
  logic [7:0]        input_ch_q, input_ch_d;
  logic              ch_valid_q, ch_valid_d;
  logic              overflow_q, overflow_d;
  logic              match_valid_q, match_valid_d;
  logic [ADDR_W-1:0] match_offset_q, match_offset_d;
  logic [7:0]        match_count_q, match_count_d;
  logic              mat_reset_q, ready_q, busy_q, done_q;
  logic              dly_v_q [MATCH_LAT];
  logic [ADDR_W-1:0] dly_p_q [MATCH_LAT];
  logic              mem_we_s;

  // Next-state, datapath and match-capture logic.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    len_d          = len_q;
    drain_d        = drain_q;
    input_ch_d     = 8'd0;
    ch_valid_d     = 1'b0;
    match_offset_d = match_offset_q;
    match_count_d  = match_count_q;
    match_valid_d  = 1'b0;
    mem_we_s       = 1'b0;
    overflow_d     = overflow_q | (bus.wr_en & (state_q != S_LOAD));

    // The tail of the delay line lines ifFinal up with the character it judges.
    if (dly_v_q[MATCH_LAT-1] && bus.ifFinal) begin
      match_valid_d  = 1'b1;
      match_offset_d = dly_p_q[MATCH_LAT-1];
      match_count_d  = (match_count_q == 8'd255) ? 8'd255 : match_count_q + 8'd1;
    end else begin
      match_valid_d  = 1'b0;
    end

    case (state_q)
      S_LOAD: begin
        if (bus.wr_en) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (bus.wr_last || (wr_ptr_q == ADDR_W'(DEPTH - 1))) begin
            len_d   = {1'b0, wr_ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
            state_d = S_READY;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_READY: begin
        if (bus.start) begin
          state_d       = S_PRIME;
          match_count_d = 8'd0;
        end else begin
          state_d = S_READY;
        end
      end
      S_PRIME: begin
        state_d    = S_STREAM;
        rd_ptr_d   = {ADDR_W{1'b0}};
        input_ch_d = mem_q[{ADDR_W{1'b0}}];
        ch_valid_d = 1'b1;
      end
      S_STREAM: begin
        if ({1'b0, rd_ptr_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1})) begin
          state_d = S_DRAIN;
          drain_d = 3'd0;
        end else begin
          rd_ptr_d   = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          input_ch_d = mem_q[rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1}];
          ch_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(MATCH_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d  = S_LOAD;
        wr_ptr_d = {ADDR_W{1'b0}};
        rd_ptr_d = {ADDR_W{1'b0}};
        len_d    = {(ADDR_W+1){1'b0}};
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State, registered outputs and the (valid, index) delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_LOAD;
      wr_ptr_q       <= {ADDR_W{1'b0}};
      rd_ptr_q       <= {ADDR_W{1'b0}};
      len_q          <= {(ADDR_W+1){1'b0}};
      drain_q        <= 3'd0;
      input_ch_q     <= 8'd0;
      ch_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      match_valid_q  <= 1'b0;
      match_offset_q <= {ADDR_W{1'b0}};
      match_count_q  <= 8'd0;
      mat_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < MATCH_LAT; i++) begin
        dly_v_q[i] <= 1'b0;
        dly_p_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      drain_q        <= drain_d;
      input_ch_q     <= input_ch_d;
      ch_valid_q     <= ch_valid_d;
      overflow_q     <= overflow_d;
      match_valid_q  <= match_valid_d;
      match_offset_q <= match_offset_d;
      match_count_q  <= match_count_d;
      mat_reset_q    <= (state_d == S_PRIME);
      ready_q        <= (state_d == S_READY);
      busy_q         <= (state_d == S_PRIME) || (state_d == S_STREAM) || (state_d == S_DRAIN);
      done_q         <= (state_d == S_DONE);
      dly_v_q[0]     <= ch_valid_q;
      dly_p_q[0]     <= rd_ptr_q;
      for (int i = 1; i < MATCH_LAT; i++) begin
        dly_v_q[i] <= dly_v_q[i-1];
        dly_p_q[i] <= dly_p_q[i-1];
      end
    end
  end

  // Payload storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.input_ch     = input_ch_q;
  assign bus.ch_valid     = ch_valid_q;
  assign bus.mat_reset    = mat_reset_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = overflow_q;
  assign bus.match_valid  = match_valid_q;
  assign bus.match_offset = match_offset_q;
  assign bus.match_count  = match_count_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_payload_feeder.sv
// Scoreboard bench for payload_feeder: stimulus predicts cycle-stamped events
// from the stream rules, a negedge monitor pops and compares them.
module tb_payload_feeder;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2;

  typedef struct {
    int cyc;
    int val;
    int off;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  payload_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  payload_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MATCH_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ev_t        q_ch[$], q_mr[$], q_mt[$], q_dn[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         ovf_exp = 1'b0;
  bit         iff_at [0:65535];
  logic [7:0] mbuf [DEPTH];
  logic [7:0] pl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle counter and matcher model: ifFinal follows the planned schedule.
  initial begin
    bus.ifFinal = 1'b0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1 bus.ifFinal = iff_at[cyc];
    end
  end

  // Monitor: every cycle, compare DUT outputs with the due scoreboard entries.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q_ch.size() > 0 && q_ch[0].cyc == cyc) begin
          e = q_ch.pop_front();
          check("ch_valid", bus.ch_valid, 1);
          check("input_ch", bus.input_ch, e.val);
          check("busy_streaming", bus.busy, 1);
        end else if (bus.ch_valid) begin
          check("ch_valid_spurious", bus.ch_valid, 0);
        end else begin
          check("input_ch_idle", bus.input_ch, 0);
        end
        if (q_mr.size() > 0 && q_mr[0].cyc == cyc) begin
          e = q_mr.pop_front();
          check("mat_reset", bus.mat_reset, 1);
        end else if (bus.mat_reset) begin
          check("mat_reset_spurious", bus.mat_reset, 0);
        end
        if (q_mt.size() > 0 && q_mt[0].cyc == cyc) begin
          e = q_mt.pop_front();
          check("match_valid", bus.match_valid, 1);
          check("match_offset", bus.match_offset, e.off);
          check("match_count", bus.match_count, e.cnt);
        end else if (bus.match_valid) begin
          check("match_valid_spurious", bus.match_valid, 0);
        end
        if (q_dn.size() > 0 && q_dn[0].cyc == cyc) begin
          e = q_dn.pop_front();
          check("done", bus.done, 1);
          check("done_match_count", bus.match_count, e.cnt);
        end else if (bus.done) begin
          check("done_spurious", bus.done, 0);
        end
      end
    end
  end

  task automatic flush();
    q_ch.delete();
    q_mr.delete();
    q_mt.delete();
    q_dn.delete();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_ch_valid", bus.ch_valid, 0);
    check("rst_input_ch", bus.input_ch, 0);
    check("rst_mat_reset", bus.mat_reset, 1);
    check("rst_ready", bus.ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_match_valid", bus.match_valid, 0);
    check("rst_match_offset", bus.match_offset, 0);
    check("rst_match_count", bus.match_count, 0);
    check("rst_done", bus.done, 0);
    tick();
    reset = 1'b0;
    tick();
    flush();
    ovf_exp = 1'b0;
    mon_en = 1'b1;
  endtask

  // Write every byte of pl from address 0; ready must rise only after the final one.
  task automatic load(input bit use_last);
    for (int i = 0; i < pl.size(); i++) begin
      mbuf[i] = pl[i];
      bus.wr_en = 1'b1;
      bus.wr_data = pl[i];
      bus.wr_last = use_last && (i == pl.size() - 1);
      tick();
      bus.wr_en = 1'b0;
      bus.wr_last = 1'b0;
      check("ready_during_load", bus.ready, (i == pl.size() - 1) ? 1 : 0);
    end
    check("overflow_after_load", bus.overflow, ovf_exp);
  endtask

  // mode 0: random ifFinal noise, 1: ifFinal always high, 2: one pulse for offset hit.
  task automatic run_stream(input int n, input int mode, input int hit,
                            input bit wr_in_ready, input bit wr_in_stream, input bit start_in_done);
    int e;
    int cnt;
    e = cyc + 1;
    for (int w = e; w <= e + n + LAT + 2; w++) begin
      case (mode)
        0:       iff_at[w] = ($urandom_range(0, 1) == 1);
        1:       iff_at[w] = 1'b1;
        default: iff_at[w] = (w == e + 1 + hit + LAT);
      endcase
    end
    q_mr.push_back('{e, 1, 0, 0});
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      q_ch.push_back('{e + 1 + k, int'(mbuf[k]), 0, 0});
      if (iff_at[e + 1 + k + LAT]) begin
        cnt = (cnt < 255) ? cnt + 1 : 255;
        q_mt.push_back('{e + k + LAT + 2, 0, k, cnt});
      end
    end
    q_dn.push_back('{e + n + LAT + 1, 0, 0, cnt});
    bus.start = 1'b1;
    if (wr_in_ready) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hEE;
      ovf_exp = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (wr_in_stream) begin
      tick();
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h5A;
      ovf_exp = 1'b1;
      tick();
      bus.wr_en = 1'b0;
    end
    while (cyc < e + n + LAT + 1) tick();
    if (start_in_done) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ready_after_done", bus.ready, 0);
    check("busy_after_done", bus.busy, 0);
    check("overflow_sticky", bus.overflow, ovf_exp);
    check("match_count_hold", bus.match_count, cnt);
    tick();
    check("busy_after_done_start", bus.busy, 0);
  endtask

  // Reset while the fourth byte is on input_ch.
  task automatic reset_mid_stream();
    int e;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    load(1'b1);
    e = cyc + 1;
    q_mr.push_back('{e, 1, 0, 0});
    for (int k = 0; k < 4; k++) q_ch.push_back('{e + 1 + k, int'(mbuf[k]), 0, 0});
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < e + 4) tick();
    reset = 1'b1;
    @(negedge clk);
    #1 mon_en = 1'b0;
    tick();
    check("midrst_ch_valid", bus.ch_valid, 0);
    check("midrst_match_count", bus.match_count, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_mat_reset", bus.mat_reset, 1);
    check("midrst_pending_bytes", q_ch.size(), 0);
    reset = 1'b0;
    tick();
    flush();
    ovf_exp = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'd0;
    bus.wr_last = 1'b0;
    bus.start = 1'b0;
    do_reset();

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("start_in_load_busy", bus.busy, 0);
    check("start_in_load_ready", bus.ready, 0);

    pl = '{8'd97, 8'd112, 8'd111, 8'd119, 8'd101, 8'd102, 8'd103, 8'd104};
    load(1'b1);
    run_stream(8, 2, -100, 1'b0, 1'b0, 1'b1);
    load(1'b1);
    run_stream(8, 2, 3, 1'b0, 1'b0, 1'b0);

    pl = '{8'd1, 8'd2, 8'd3};
    load(1'b1);
    run_stream(3, 1, 0, 1'b0, 1'b0, 1'b0);

    reset_mid_stream();
    pl = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    load(1'b1);
    run_stream(5, 0, 0, 1'b0, 1'b0, 1'b0);

    pl.delete();
    for (int i = 0; i < DEPTH; i++) pl.push_back(8'($urandom));
    load(1'b0);
    check("full_overflow_before", bus.overflow, 0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    ovf_exp = 1'b1;
    check("full_overflow_after", bus.overflow, 1);
    check("full_ready_kept", bus.ready, 1);
    run_stream(DEPTH, 1, 0, 1'b0, 1'b0, 1'b1);

    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(1, 24);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      load(1'b1);
      run_stream(n, 0, 0, it == 3, it == 6, (it % 2) == 1);
    end

    repeat (4) tick();
    check("leftover_events", q_ch.size() + q_mr.size() + q_mt.size() + q_dn.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
